// File: rtl/sprite_blitter_multi.sv
// Sprite blitter: each frame walks the slot table and streams clipped, transparency-masked
// sprite words from an internal sprite RAM to the SDRAM write port.
module sprite_blitter_multi #(
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 22,
  parameter int                NUM_SLOTS   = 16,
  parameter int                SPR_DEPTH   = 512,
  parameter int                LINE_WORDS  = 40,
  parameter int                SCREEN_H    = 480,
  parameter logic [ADDR_W-1:0] FB0_BASE    = 22'h100000,
  parameter logic [ADDR_W-1:0] FB1_BASE    = 22'h200000,
  parameter logic [7:0]        TRANSPARENT = 8'hFF,
  localparam int               BYTES       = DATA_W / 8,
  localparam int               SLOT_W      = $clog2(NUM_SLOTS),
  localparam int               SPR_AW      = $clog2(SPR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              frame_flip,
  input  logic              cmd_wr,
  input  logic [SLOT_W-1:0] cmd_idx,
  input  logic [39:0]       cmd_data,
  input  logic              spr_wr,
  input  logic [SPR_AW-1:0] spr_wraddr,
  input  logic [DATA_W-1:0] spr_wdata,
  input  logic              sdram_wait,
  input  logic              sdram_ac,
  output logic              sdram_wr,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_data,
  output logic [BYTES-1:0]  sdram_be,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [3:0] {
    IDLE, EXAMINE, ROW, READ, RDWAIT, WRITE, ADV, NEXT, DONE
  } state_t;

  state_t state_reg, state_next;

  // Slot table: enable bits are reset, geometry fields are plain storage.
  // Field layout: [37:27] y, [26:21] x_word, [20:17] w_words, [16:9] h, [8:0] ram_base
  logic [NUM_SLOTS-1:0] slot_en_reg;
  logic [37:0]          slot_fields [NUM_SLOTS];
  logic [37:0]          cur_fields;
  logic                 unused_cmd_bit;

  logic [DATA_W-1:0] spr_mem [SPR_DEPTH];
  logic [DATA_W-1:0] spr_q;

  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic              flip_reg, flip_next;
  logic [10:0]       y_reg, y_next;
  logic [5:0]        x_reg, x_next;
  logic [3:0]        w_reg, w_next;
  logic [7:0]        h_reg, h_next;
  logic [7:0]        r_reg, r_next;
  logic [3:0]        i_reg, i_next;
  logic [SPR_AW-1:0] rd_reg, rd_next;
  logic              pend_reg, pend_next;
  logic              pend_flip_reg, pend_flip_next;
  logic              overrun_reg, overrun_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [BYTES-1:0]  be_reg, be_next;

  logic [11:0]       line;
  logic              off_screen;
  logic [6:0]        col;
  logic              col_drop;
  logic [BYTES-1:0]  be_calc;
  logic [ADDR_W-1:0] fb_base;
  logic [ADDR_W-1:0] addr_calc;

  assign unused_cmd_bit = cmd_data[9];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_en_reg <= '0;
    end else if (cmd_wr) begin
      slot_en_reg[cmd_idx] <= cmd_data[39];
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_wr) slot_fields[cmd_idx] <= {cmd_data[38:10], cmd_data[8:0]};
  end

  // Registered read: a write to the address being read returns the old word.
  always_ff @(posedge clk) begin
    if (spr_wr) spr_mem[spr_wraddr] <= spr_wdata;
    spr_q <= spr_mem[rd_reg];
  end

  assign cur_fields = slot_fields[slot_reg];

  // line is a 12-bit two's-complement value: sign-extended y plus row index
  assign line       = {y_reg[10], y_reg} + {4'd0, r_reg};
  assign off_screen = line[11] || (line >= 12'(SCREEN_H));
  assign col        = 7'(x_reg) + 7'(i_reg);
  assign col_drop   = col >= 7'(LINE_WORDS);
  assign fb_base    = flip_reg ? FB1_BASE : FB0_BASE;
  assign addr_calc  = fb_base + ADDR_W'(line) * ADDR_W'(LINE_WORDS) + ADDR_W'(col);

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_be
      assign be_calc[gi] = spr_q[gi*8 +: 8] != TRANSPARENT;
    end
  endgenerate

  assign busy       = (state_reg != IDLE) && (state_reg != DONE);
  assign done       = state_reg == DONE;
  assign sdram_wr   = state_reg == WRITE;
  assign sdram_addr = addr_reg;
  assign sdram_data = data_reg;
  assign sdram_be   = be_reg;
  assign overrun    = overrun_reg;

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    flip_next      = flip_reg;
    y_next         = y_reg;
    x_next         = x_reg;
    w_next         = w_reg;
    h_next         = h_reg;
    r_next         = r_reg;
    i_next         = i_reg;
    rd_next        = rd_reg;
    pend_next      = pend_reg;
    pend_flip_next = pend_flip_reg;
    overrun_next   = 1'b0;
    addr_next      = addr_reg;
    data_next      = data_reg;
    be_next        = be_reg;

    if (busy && new_frame) begin
      overrun_next   = 1'b1;
      pend_next      = 1'b1;
      pend_flip_next = frame_flip;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (new_frame) begin
          state_next = EXAMINE;
          slot_next  = '0;
          flip_next  = frame_flip;
        end
      end
      EXAMINE: begin
        y_next  = cur_fields[37:27];
        x_next  = cur_fields[26:21];
        w_next  = cur_fields[20:17];
        h_next  = cur_fields[16:9];
        r_next  = '0;
        i_next  = '0;
        rd_next = SPR_AW'(cur_fields[8:0]);
        if (slot_en_reg[slot_reg] && cur_fields[20:17] != 4'd0 && cur_fields[16:9] != 8'd0)
          state_next = ROW;
        else
          state_next = NEXT;
      end
      ROW: begin
        if (off_screen) begin
          rd_next    = rd_reg + SPR_AW'(w_reg);
          r_next     = r_reg + 8'd1;
          state_next = (r_reg + 8'd1 == h_reg) ? NEXT : ROW;
        end else begin
          state_next = READ;
        end
      end
      READ: state_next = RDWAIT;
      RDWAIT: begin
        if (col_drop || be_calc == '0) begin
          state_next = ADV;
        end else if (!sdram_wait) begin
          state_next = WRITE;
          addr_next  = addr_calc;
          data_next  = spr_q;
          be_next    = be_calc;
        end
      end
      WRITE: if (sdram_ac) state_next = ADV;
      ADV: begin
        rd_next = rd_reg + SPR_AW'(1);
        if (i_reg + 4'd1 == w_reg) begin
          i_next     = '0;
          r_next     = r_reg + 8'd1;
          state_next = (r_reg + 8'd1 == h_reg) ? NEXT : ROW;
        end else begin
          i_next     = i_reg + 4'd1;
          state_next = READ;
        end
      end
      NEXT: begin
        if (slot_reg == SLOT_W'(NUM_SLOTS - 1)) begin
          state_next = DONE;
        end else begin
          slot_next  = slot_reg + SLOT_W'(1);
          state_next = EXAMINE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A restart waits only for a write already on the bus to be accepted.
    if (busy && (new_frame || pend_reg) && !(state_reg == WRITE && !sdram_ac)) begin
      state_next = EXAMINE;
      slot_next  = '0;
      flip_next  = new_frame ? frame_flip : pend_flip_reg;
      pend_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      slot_reg      <= '0;
      flip_reg      <= 1'b0;
      y_reg         <= '0;
      x_reg         <= '0;
      w_reg         <= '0;
      h_reg         <= '0;
      r_reg         <= '0;
      i_reg         <= '0;
      rd_reg        <= '0;
      pend_reg      <= 1'b0;
      pend_flip_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      be_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      flip_reg      <= flip_next;
      y_reg         <= y_next;
      x_reg         <= x_next;
      w_reg         <= w_next;
      h_reg         <= h_next;
      r_reg         <= r_next;
      i_reg         <= i_next;
      rd_reg        <= rd_next;
      pend_reg      <= pend_next;
      pend_flip_reg <= pend_flip_next;
      overrun_reg   <= overrun_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      be_reg        <= be_next;
    end
  end

endmodule

// File: tb/tb_sprite_blitter_multi.sv
// Directed bench for sprite_blitter_multi: a slot-table model predicts every SDRAM write,
// queued at stimulus time and matched by a monitor on each accepted request.
module tb_sprite_blitter_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic         new_frame, frame_flip, cmd_wr, spr_wr, sdram_wait, sdram_ac;
  logic [3:0]   cmd_idx;
  logic [39:0]  cmd_data;
  logic [8:0]   spr_wraddr;
  logic [127:0] spr_wdata;
  logic         sdram_wr, busy, done, overrun;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_data;
  logic [15:0]  sdram_be;

  typedef struct packed {
    logic [21:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  wr_t          exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           m_en [16];
  int           m_y [16], m_x [16], m_w [16], m_h [16], m_base [16];
  logic [127:0] m_ram [512];
  logic [127:0] tmp_word;
  logic [21:0]  hold_addr;

  sprite_blitter_multi dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .frame_flip(frame_flip),
    .cmd_wr(cmd_wr), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .spr_wr(spr_wr), .spr_wraddr(spr_wraddr), .spr_wdata(spr_wdata),
    .sdram_wait(sdram_wait), .sdram_ac(sdram_ac), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_be(sdram_be),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int idx, input bit en, input int y, input int x,
                            input int w, input int h, input int base);
    logic [10:0] y11;
    y11      = y[10:0];
    cmd_idx  = idx[3:0];
    cmd_data = {en, y11, x[5:0], w[3:0], h[7:0], 1'b0, base[8:0]};
    cmd_wr   = 1'b1;
    step();
    cmd_wr   = 1'b0;
    m_en[idx] = en; m_y[idx] = y; m_x[idx] = x; m_w[idx] = w; m_h[idx] = h; m_base[idx] = base;
  endtask

  task automatic write_spr(input int addr, input logic [127:0] data);
    spr_wraddr = addr[8:0];
    spr_wdata  = data;
    spr_wr     = 1'b1;
    step();
    spr_wr     = 1'b0;
    m_ram[addr] = data;
  endtask

  // Reference walk: every word of every enabled slot, in slot/row/column order.
  task automatic push_frame(input bit flip);
    wr_t e;
    int  rd, line, fb;
    fb = flip ? 32'h200000 : 32'h100000;
    for (int s = 0; s < 16; s++) begin
      if (m_en[s] && m_w[s] != 0 && m_h[s] != 0) begin
        rd = m_base[s];
        for (int r = 0; r < m_h[s]; r++) begin
          line = m_y[s] + r;
          for (int i = 0; i < m_w[s]; i++) begin
            if (line >= 0 && line < 480 && m_x[s] + i < 40) begin
              e.data = m_ram[rd % 512];
              for (int b = 0; b < 16; b++) e.be[b] = (e.data[b*8 +: 8] != 8'hFF);
              e.addr = 22'(fb + line * 40 + m_x[s] + i);
              if (e.be != 16'h0) exp_q.push_back(e);
            end
            rd++;
          end
        end
      end
    end
  endtask

  task automatic pulse_frame(input bit flip);
    frame_flip = flip;
    new_frame  = 1'b1;
    step();
    new_frame  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 4000 && done !== 1'b1; n++) step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input bit flip, input string tag);
    push_frame(flip);
    pulse_frame(flip);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done_cleared"}, done, 0);
    wait_done(tag);
  endtask

  task automatic wait_wr(input string tag);
    for (int n = 0; n < 200 && sdram_wr !== 1'b1; n++) step();
    chk({tag, "_wr_seen"}, sdram_wr, 1);
  endtask

  // Monitor: matches accepted writes and checks that a held request does not change.
  logic         held = 1'b0;
  logic [21:0]  held_addr;
  logic [127:0] held_data;
  logic [15:0]  held_be;
  wr_t          mon_e;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("held_wr", sdram_wr, 1);
        chk("held_addr", sdram_addr, held_addr);
        chk("held_data", sdram_data, held_data);
        chk("held_be", sdram_be, held_be);
      end
      if (sdram_wr && sdram_ac) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr %h expected no write", sdram_addr);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", sdram_addr, mon_e.addr);
          chk("wr_data", sdram_data, mon_e.data);
          chk("wr_be", sdram_be, mon_e.be);
        end
      end
      held      = sdram_wr && !sdram_ac;
      held_addr = sdram_addr;
      held_data = sdram_data;
      held_be   = sdram_be;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; new_frame = 1'b0; frame_flip = 1'b0; cmd_wr = 1'b0; cmd_idx = '0;
    cmd_data = '0; spr_wr = 1'b0; spr_wraddr = '0; spr_wdata = '0;
    sdram_wait = 1'b0; sdram_ac = 1'b1;
    for (int s = 0; s < 16; s++) m_en[s] = 1'b0;
    repeat (3) step();
    chk("rst_wr", sdram_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_be", sdram_be, 0);
    reset = 1'b0;
    step();

    // Sprite RAM: 0..47 opaque, 48 fully transparent, 49..55 opaque, 56..63 alternating 00/FF
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 16; b++) begin
        if (k == 48)      tmp_word[b*8 +: 8] = 8'hFF;
        else if (k >= 56) tmp_word[b*8 +: 8] = (b % 2 == 0) ? 8'h00 : 8'hFF;
        else              tmp_word[b*8 +: 8] = 8'((k * 7 + b * 3) & 127);
      end
      write_spr(k, tmp_word);
    end

    // Basic 3x2 sprite
    write_slot(0, 1, 10, 1, 3, 2, 0);
    run_frame(0, "basic");

    // Vertical clipping at top and bottom
    write_slot(0, 0, 10, 1, 3, 2, 0);
    write_slot(1, 1, -1, 0, 2, 3, 16);
    write_slot(2, 1, 479, 3, 1, 4, 24);
    run_frame(0, "vclip");

    // Horizontal clipping and a fully transparent word
    write_slot(1, 0, -1, 0, 2, 3, 16);
    write_slot(2, 0, 479, 3, 1, 4, 24);
    write_slot(3, 1, 200, 38, 4, 1, 30);
    write_slot(4, 1, 100, 0, 2, 1, 48);
    run_frame(0, "hclip");

    // Mixed transparency into buffer 1
    write_slot(3, 0, 200, 38, 4, 1, 30);
    write_slot(4, 0, 100, 0, 2, 1, 48);
    write_slot(5, 1, 300, 10, 2, 2, 56);
    run_frame(1, "mixed_flip");

    // Busy SDRAM: no request while waiting, then a request held through wait toggles
    write_slot(5, 0, 300, 10, 2, 2, 56);
    write_slot(6, 1, 20, 5, 2, 1, 2);
    push_frame(0);
    sdram_ac = 1'b0;
    sdram_wait = 1'b1;
    pulse_frame(0);
    repeat (10) step();
    chk("wait_blocks_wr", sdram_wr, 0);
    sdram_wait = 1'b0;
    wait_wr("hold");
    hold_addr = sdram_addr;
    for (int k = 0; k < 5; k++) begin
      sdram_wait = ~sdram_wait;
      step();
      chk("hold_wr_direct", sdram_wr, 1);
      chk("hold_addr_direct", sdram_addr, hold_addr);
    end
    sdram_wait = 1'b0;
    sdram_ac = 1'b1;
    wait_done("hold");

    // new_frame mid-walk restarts at slot 0 with the new flip
    write_slot(6, 0, 20, 5, 2, 1, 2);
    write_slot(7, 1, 50, 0, 4, 4, 0);
    push_frame(0);
    pulse_frame(0);
    chk("no_overrun_from_done", overrun, 0);
    for (int n = 0; n < 300 && exp_q.size() > 13; n++) step();
    chk("overrun_progress", exp_q.size() <= 13, 1);
    frame_flip = 1'b1;
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    chk("overrun_pulse", overrun, 1);
    chk("overrun_busy", busy, 1);
    exp_q.delete();
    push_frame(1);
    step();
    chk("overrun_one_cycle", overrun, 0);
    wait_done("restart");

    // Asynchronous reset while a write is held
    write_slot(7, 0, 50, 0, 4, 4, 0);
    write_slot(8, 1, 5, 0, 2, 1, 0);
    push_frame(0);
    sdram_ac = 1'b0;
    pulse_frame(0);
    wait_wr("rstwr");
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_wr", sdram_wr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    exp_q.delete();
    for (int s = 0; s < 16; s++) m_en[s] = 1'b0;
    sdram_ac = 1'b1;
    step();
    reset = 1'b0;
    step();
    run_frame(0, "after_rst_empty");

    // Sprite RAM contents survive reset
    write_slot(8, 1, 5, 0, 2, 1, 0);
    run_frame(0, "ram_kept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
